// File: rtl/lzc.sv
// Streaming leading-zero counter over WORD beats of WIDTH bits.
// Chained (mode=1) or per-beat-sum (mode=0) count, one result per group.
module lzc #(
  parameter int WIDTH = 8,
  parameter int WORD  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [WIDTH-1:0]                  data,
  input  logic                              Ivalid,
  input  logic                              mode,
  output logic [$clog2(WIDTH*WORD):0]       zeros,
  output logic                              Ovalid
);

  localparam int ZW = $clog2(WIDTH*WORD) + 1;
  localparam int CW = (WORD > 1) ? $clog2(WORD) : 1;

  logic [CW-1:0] cnt;
  logic [ZW-1:0] acc;
  logic          found;
  logic          mode_q;

  logic [ZW-1:0] lzv;
  logic [ZW-1:0] add;
  logic [ZW-1:0] acc_nxt;
  logic          first;
  logic          last;
  logic          cur_mode;

  // Priority encoder: highest set bit wins, all-zero gives WIDTH.
  always_comb begin
    lzv = ZW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) lzv = ZW'(WIDTH - 1 - i);
    end
  end

  assign first    = (cnt == '0);
  assign last     = (cnt == CW'(WORD - 1));
  assign cur_mode = first ? mode : mode_q;
  assign add      = (cur_mode && found) ? '0 : lzv;
  assign acc_nxt  = acc + add;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      found  <= 1'b0;
      mode_q <= 1'b0;
      zeros  <= '0;
      Ovalid <= 1'b0;
    end else begin
      Ovalid <= Ivalid && last;
      if (Ivalid) begin
        mode_q <= cur_mode;
        if (last) begin
          zeros <= acc_nxt;
          cnt   <= '0;
          acc   <= '0;
          found <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
          acc <= acc_nxt;
          if (cur_mode && data != '0) found <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lzc.sv
// Bench for lzc: directed spec groups plus random groups
// against a whole-value leading-zero model.
module tb_lzc;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       Ivalid;
  logic       mode;
  logic [5:0] zeros;
  logic       Ovalid;

  int checks = 0;
  int errors = 0;

  lzc #(.WIDTH(8), .WORD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .Ivalid(Ivalid),
    .mode  (mode),
    .zeros (zeros),
    .Ovalid(Ovalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lz32(logic [31:0] v);
    for (int i = 31; i >= 0; i--)
      if (v[i]) return 31 - i;
    return 32;
  endfunction

  function automatic int lz8(logic [7:0] v);
    for (int i = 7; i >= 0; i--)
      if (v[i]) return 7 - i;
    return 8;
  endfunction

  function automatic int model(logic [31:0] v, bit m);
    int s;
    if (m) return lz32(v);
    s = 0;
    for (int b = 0; b < 4; b++) s += lz8(v[31-8*b -: 8]);
    return s;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat(logic [7:0] d, bit m);
    @(negedge clk);
    data = d;
    mode = m;
    Ivalid = 1'b1;
    @(posedge clk);
    #1;
    Ivalid = 1'b0;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      Ivalid = 1'b0;
      data = 8'($urandom);
      mode = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  // gaps: bit b set means idle cycles after beat b
  task automatic group(string tag, logic [31:0] v, bit m,
                       logic [2:0] gaps, bit tog, bit hold);
    int exp;
    exp = model(v, m);
    for (int b = 0; b < 4; b++) begin
      beat(v[31-8*b -: 8], (b == 0) ? m : (tog ? ~m : m));
      if (b < 3) begin
        chk({tag, "_early"}, 32'(Ovalid), 32'd0);
        if (gaps[b]) idle($urandom_range(1, 2));
      end
    end
    chk({tag, "_ovalid"}, 32'(Ovalid), 32'd1);
    chk({tag, "_zeros"}, 32'(zeros), 32'(exp));
    if (hold) begin
      idle(1);
      chk({tag, "_pulse"}, 32'(Ovalid), 32'd0);
      chk({tag, "_hold"}, 32'(zeros), 32'(exp));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    data = '0;
    Ivalid = 1'b0;
    mode = 1'b0;
    #12;
    chk("rst_zeros", 32'(zeros), 32'd0);
    chk("rst_ovalid", 32'(Ovalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    group("t1m1", 32'h003F000F, 1'b1, 3'b000, 1'b0, 1'b1);
    group("t1m0", 32'h003F000F, 1'b0, 3'b000, 1'b0, 1'b1);
    group("t2m1", 32'h01010101, 1'b1, 3'b000, 1'b0, 1'b0);
    group("t2m0", 32'h01010101, 1'b0, 3'b000, 1'b0, 1'b1);
    group("t3m1", 32'h3F3F3F00, 1'b1, 3'b111, 1'b0, 1'b1);
    group("t3m0", 32'h3F3F3F00, 1'b0, 3'b111, 1'b0, 1'b1);
    group("t4m1", 32'h103FFF00, 1'b1, 3'b000, 1'b0, 1'b0);
    group("t4m0", 32'h103FFF00, 1'b0, 3'b000, 1'b0, 1'b1);
    group("t5m1", 32'h00000000, 1'b1, 3'b000, 1'b0, 1'b1);
    group("t5m0g", 32'h00000000, 1'b0, 3'b101, 1'b0, 1'b1);
    idle(3);
    chk("t5_hold32", 32'(zeros), 32'd32);

    // reset mid-group, then a fresh group with mode toggling
    beat(8'h00, 1'b1);
    beat(8'h00, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_zeros", 32'(zeros), 32'd0);
    chk("t6_rst_ovalid", 32'(Ovalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    group("t6m1", 32'h0000F001, 1'b1, 3'b010, 1'b1, 1'b1);
    group("t6m0", 32'h0000F001, 1'b0, 3'b000, 1'b1, 1'b1);

    for (int g = 0; g < 60; g++) begin
      logic [31:0] v;
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) v[23:16] = 8'h00;
      group("rnd", v, 1'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom));
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
